imem_loader: RTL

- Writer side of the instruction memory: receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Issues one word write per assembled word into instruction memory, at consecutive word-aligned byte addresses starting at 0.
- Holds the CPU in reset (cpu_rst) until a complete program image has been written; the CPU then fetches from memory the loader filled.

---
 rtl/imem_loader_if.sv | 20 ++
 rtl/imem_loader.sv | 130 +++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus between the loader and its environment.
// The loader takes the slave view; the byte source / memory side takes the master view.
interface imem_loader_if;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   modport master (
      output byte_valid, byte_data,
      input  byte_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  byte_valid, byte_data,
      output byte_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles little-endian words from a byte stream, writes them at
// consecutive word addresses, and holds the CPU in reset until a complete image is present.
module imem_loader #(
   parameter int DEPTH = 16000,
   parameter int LEN_W = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [LEN_W-1:0] load_len_i,
   imem_loader_if.slave     bus,
   output logic             cpu_rst_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             error_o,
   output logic [LEN_W-1:0] words_written_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RECV  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [1:0]       cnt_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] widx_q;
   logic [LEN_W-1:0] ww_q;
   logic             error_q;
   logic [31:0]      mem_addr_q;
   logic [31:0]      mem_wdata_q;
   logic [23:0]      asm_q;

   logic start_ok, start_bad, byte_acc, last_byte, last_word, len_bad;

   assign len_bad   = (load_len_i == '0) || (load_len_i > LEN_W'(DEPTH));
   // A byte that arrives together with abort is discarded along with the partial word.
   assign byte_acc  = (state_q == S_RECV) && bus.byte_valid && !abort_i;
   assign last_byte = byte_acc && (cnt_q == 2'd3);
   assign last_word = (ww_q + 1'b1) == len_q;

   always_comb begin
      state_d   = state_q;
      start_ok  = 1'b0;
      start_bad = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i && !abort_i) begin
               if (len_bad) begin
                  start_bad = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  start_ok = 1'b1;
                  state_d  = S_RECV;
               end
            end
         end
         S_RECV: begin
            if (abort_i)        state_d = S_IDLE;
            else if (last_byte) state_d = S_WRITE;
         end
         S_WRITE: begin
            if (abort_i)        state_d = S_IDLE;
            else if (last_word) state_d = S_DONE;
            else                state_d = S_RECV;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         widx_q      <= '0;
         ww_q        <= '0;
         error_q     <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (start_bad) begin
            error_q <= 1'b1;
            ww_q    <= '0;
         end
         if (start_ok) begin
            error_q <= 1'b0;
            len_q   <= load_len_i;
            widx_q  <= '0;
            ww_q    <= '0;
            cnt_q   <= '0;
         end
         if (byte_acc) cnt_q <= cnt_q + 2'd1;
         if (last_byte) begin
            mem_addr_q  <= {{(30-LEN_W){1'b0}}, widx_q, 2'b00};
            mem_wdata_q <= {bus.byte_data, asm_q};
         end
         // The write strobe is already out during WRITE, so the word counts even on abort.
         if (state_q == S_WRITE) begin
            widx_q <= widx_q + 1'b1;
            ww_q   <= ww_q + 1'b1;
            cnt_q  <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (byte_acc) begin
         case (cnt_q)
            2'd0:    asm_q[7:0]   <= bus.byte_data;
            2'd1:    asm_q[15:8]  <= bus.byte_data;
            2'd2:    asm_q[23:16] <= bus.byte_data;
            default: asm_q        <= asm_q;
         endcase
      end
   end

   assign bus.byte_ready  = (state_q == S_RECV);
   assign bus.mem_we      = (state_q == S_WRITE);
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign cpu_rst_o       = (state_q != S_DONE);
   assign busy_o          = (state_q == S_RECV) || (state_q == S_WRITE);
   assign done_o          = (state_q == S_DONE);
   assign error_o         = error_q;
   assign words_written_o = ww_q;

endmodule
